// File: rtl/prog_mem_pkg.sv
// ============================================================================
// Module   : prog_mem_pkg
// Brief    : Shared program-memory geometry and writer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_mem_pkg;

    localparam int PROG_ADDR_W = 12;
    localparam int NIB_W       = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/wr_addr_counter.sv
// ============================================================================
// Module   : wr_addr_counter
// Brief    : Loadable write-address counter with carry out at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wr_addr_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_carry
);

    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    // Carry marks the increment that rolls the address over to zero.
    assign o_carry = i_en & (&r_count);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/program_writer.sv
// ============================================================================
// Module   : program_writer
// Brief    : Packs instr/oprnd nibble pairs into bytes and writes them to
//            consecutive program memory addresses from a loadable base.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_writer
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = prog_mem_pkg::PROG_ADDR_W,
    parameter int NIB_W  = prog_mem_pkg::NIB_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   byte_count,
    input  logic                nib_valid,
    input  logic [NIB_W-1:0]    nib_data,
    output logic                nib_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [2*NIB_W-1:0]  mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                wrapped
);

    wr_state_t           r_state;
    wr_state_t           w_next;
    logic                w_ready;
    logic                w_xfer;
    logic                w_begin;
    logic [NIB_W-1:0]    r_hi;
    logic [ADDR_W-1:0]   r_remaining;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [2*NIB_W-1:0]  r_mem_wdata;
    logic                r_wrapped;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_carry;

    assign w_begin = (r_state == IDLE) & start;
    assign w_xfer  = nib_valid & w_ready;

    wr_addr_counter #(
        .ADDR_W (ADDR_W)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_begin),
        .i_load_val (base_addr),
        .i_en       (r_state == WR),
        .o_count    (w_addr),
        .o_carry    (w_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks any transfer, so ready drops in the aborting cycle.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = HI;
            end
            HI: begin
                w_ready = ~abort;
                if (abort)          w_next = IDLE;
                else if (nib_valid) w_next = LO;
            end
            LO: begin
                w_ready = ~abort;
                if (abort)          w_next = IDLE;
                else if (nib_valid) w_next = WR;
            end
            WR: begin
                if (abort)                            w_next = IDLE;
                else if (r_remaining == ADDR_W'(1))   w_next = DONE;
                else                                  w_next = HI;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi        <= '0;
            r_remaining <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_wrapped   <= 1'b0;
        end else begin
            r_mem_we <= (r_state == LO) & w_xfer;
            if ((r_state == HI) && w_xfer) begin
                r_hi <= nib_data;
            end
            if ((r_state == LO) && w_xfer) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= {r_hi, nib_data};
            end
            // A count of zero wraps on the first decrement: full-memory session.
            if (w_begin) begin
                r_remaining <= byte_count;
            end else if (r_state == WR) begin
                r_remaining <= r_remaining - ADDR_W'(1);
            end
            if (w_begin) begin
                r_wrapped <= 1'b0;
            end else if (w_carry) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign nib_ready = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign wrapped   = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_program_writer.sv
// ============================================================================
// Module   : tb_program_writer
// Brief    : Self-checking bench for program_writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [11:0] base_addr;
    logic [11:0] byte_count;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        wrapped;

    always #5 clk = ~clk;

    program_writer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .nib_valid  (nib_valid),
        .nib_data   (nib_data),
        .nib_ready  (nib_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .wrapped    (wrapped)
    );

    typedef struct packed {
        logic [11:0] base;
        logic [11:0] count;
        logic [31:0] data;
        logic        gap;
        logic        exp_wrap;
    } vec_t;

    vec_t        tbl [5];
    logic [19:0] exp_q [$];
    logic [19:0] obs_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          overlap_cnt = 0;

    always @(negedge clk) begin
        if (mem_we)              obs_q.push_back({mem_addr, mem_wdata});
        if (mem_we && nib_ready) overlap_cnt++;
        if (done)                done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [11:0] b, input logic [11:0] c);
        base_addr  = b;
        byte_count = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n, input logic gap);
        int cyc;
        logic rdy;
        if (gap) begin
            nib_valid = 1'b0;
            @(posedge clk); #1;
        end
        nib_valid = 1'b1;
        nib_data  = n;
        cyc = 0;
        do begin
            rdy = nib_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!rdy && cyc < 20);
        if (!rdy) chk("nib_accept_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic send_byte(input logic [11:0] a, input logic [7:0] d, input logic gap);
        exp_q.push_back({a, d});
        send_nib(d[7:4], gap);
        send_nib(d[3:0], gap);
    endtask

    task automatic wait_idle(input int bound);
        int cyc;
        cyc = 0;
        while (busy && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        logic [19:0] e;
        logic [19:0] o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", o[19:8], o[7:0]);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             o[19:8], o[7:0], e[19:8], e[7:0]);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_write: got none expected addr 0x%0h data 0x%0h", e[19:8], e[7:0]);
        end
    endtask

    initial begin
        int d0;
        int ov0;
        logic [11:0] cnt;
        logic [7:0]  bv;

        tbl[0] = {12'h010, 12'd2, 32'h0000A53C, 1'b0, 1'b0};
        tbl[1] = {12'hFFF, 12'd2, 32'h00001234, 1'b0, 1'b1};
        tbl[2] = {12'h100, 12'd3, 32'h005AC3F0, 1'b1, 1'b0};
        tbl[3] = {12'h7FE, 12'd1, 32'h00000099, 1'b0, 1'b0};
        tbl[4] = {12'hFFE, 12'd4, 32'hDEADBEEF, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; abort = 1'b0; nib_valid = 1'b0;
        nib_data = '0; base_addr = '0; byte_count = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nib_ready", 32'(nib_ready), 0);
        chk("rst_mem_we",    32'(mem_we),    0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_done",      32'(done),      0);
        chk("rst_wrapped",   32'(wrapped),   0);
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            d0  = done_cnt;
            ov0 = overlap_cnt;
            pulse_start(tbl[i].base, tbl[i].count);
            chk("start_busy", 32'(busy), 1);
            chk("start_clears_wrapped", 32'(wrapped), 0);
            cnt = tbl[i].count;
            for (int b = 0; b < int'(cnt); b++) begin
                bv = 8'(tbl[i].data >> (8 * (int'(cnt) - 1 - b)));
                send_byte(tbl[i].base + 12'(b), bv, tbl[i].gap);
            end
            nib_valid = 1'b0;
            wait_idle(20);
            chk("done_pulses", 32'(done_cnt - d0), 1);
            chk("we_with_ready", 32'(overlap_cnt - ov0), 0);
            chk("wrapped", 32'(wrapped), 32'(tbl[i].exp_wrap));
            repeat (3) @(posedge clk);
            #1;
            chk("wrapped_sticky", 32'(wrapped), 32'(tbl[i].exp_wrap));
            drain();
        end

        // Reset while holding a high nibble, after a wrapping write.
        pulse_start(12'hFFF, 12'd2);
        send_byte(12'hFFF, 8'h12, 1'b0);
        send_nib(4'h3, 1'b0);
        nib_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_busy",      32'(busy),      0);
        chk("mid_rst_mem_we",    32'(mem_we),    0);
        chk("mid_rst_wrapped",   32'(wrapped),   0);
        chk("mid_rst_mem_addr",  32'(mem_addr),  0);
        chk("mid_rst_mem_wdata", 32'(mem_wdata), 0);
        chk("mid_rst_nib_ready", 32'(nib_ready), 0);
        nib_valid = 1'b1;
        nib_data  = 4'h4;
        repeat (5) @(posedge clk);
        #1;
        nib_valid = 1'b0;
        drain();

        // Abort with the next nibble presented in the same cycle.
        d0 = done_cnt;
        pulse_start(12'h300, 12'd4);
        send_byte(12'h300, 8'h77, 1'b0);
        send_nib(4'h8, 1'b0);
        nib_data = 4'hF;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        nib_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        drain();

        d0 = done_cnt;
        pulse_start(12'h400, 12'd1);
        send_byte(12'h400, 8'hC1, 1'b0);
        nib_valid = 1'b0;
        wait_idle(20);
        chk("restart_done", 32'(done_cnt - d0), 1);
        drain();

        // Full memory, with a stray start mid-session.
        d0  = done_cnt;
        ov0 = overlap_cnt;
        pulse_start(12'h000, 12'd0);
        for (int b = 0; b < 4096; b++) begin
            if (b == 100) begin
                base_addr  = 12'h555;
                byte_count = 12'd3;
                start      = 1'b1;
            end
            send_byte(12'(b), 8'(b * 7 + (b >> 8)), 1'b0);
            start = 1'b0;
        end
        nib_valid = 1'b0;
        wait_idle(20);
        chk("full_done", 32'(done_cnt - d0), 1);
        chk("full_wrapped", 32'(wrapped), 1);
        chk("full_we_with_ready", 32'(overlap_cnt - ov0), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
